// File: rtl/control_booth_pkg.sv
// rtl/control_booth_pkg.sv - shared state encoding and Booth pair constants for the Booth control unit
package control_booth_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Booth pair {q0, q_1}: 01 adds M to A, 10 subtracts M from A
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_INIT  = ST_INIT,
        S_EVAL  = ST_EVAL,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/control_booth_if.sv
// rtl/control_booth_if.sv - handshake and datapath control lines between the Booth controller and its datapath
interface control_booth_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             q0;
    logic             q_1;
    logic             init;
    logic             carga_a;
    logic             resta;
    logic             desplaza;
    logic             busy;
    logic             fin;
    logic [CNT_W-1:0] cuenta;

    // datapath / requester side
    modport master (
        output start, q0, q_1,
        input  init, carga_a, resta, desplaza, busy, fin, cuenta
    );

    // controller side
    modport slave (
        input  start, q0, q_1,
        output init, carga_a, resta, desplaza, busy, fin, cuenta
    );
endinterface

// File: rtl/control_booth_contador_iter.sv
// rtl/control_booth_contador_iter.sv - iteration down counter with load of N and a last-iteration flag
module contador_iter #(
    parameter int N     = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             last
);

    // load has priority; decrement saturates at zero so the count never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= CNT_W'(N);
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign last = (value == CNT_W'(1));

endmodule

// File: rtl/control_booth.sv
// rtl/control_booth.sv - radix-2 Booth sequential multiplier control unit
module control_booth
    import control_booth_pkg::*;
#(
    parameter int N     = 5,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    control_booth_if.slave  bus
);

    state_t           state;
    logic             init_q;
    logic             desplaza_q;
    logic             busy_q;
    logic             fin_q;
    logic             carga_a_c;
    logic             resta_c;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_val;
    logic [1:0]       pair;

    assign pair     = {bus.q0, bus.q_1};
    assign cnt_load = (state == S_INIT);
    assign cnt_dec  = (state == S_SHIFT);

    contador_iter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_contador_iter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .value (cnt_val),
        .last  (cnt_last)
    );

    // state sequencing with Moore outputs registered alongside the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            init_q     <= 1'b0;
            desplaza_q <= 1'b0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_INIT;
                        init_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_INIT: begin
                    state  <= S_EVAL;
                    init_q <= 1'b0;
                end
                S_EVAL: begin
                    state      <= S_SHIFT;
                    desplaza_q <= 1'b1;
                end
                S_SHIFT: begin
                    desplaza_q <= 1'b0;
                    if (cnt_last) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        fin_q  <= 1'b1;
                    end else begin
                        state <= S_EVAL;
                    end
                end
                S_DONE: begin
                    // start must drop before another run can be requested
                    if (!bus.start) begin
                        state <= S_IDLE;
                        fin_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    init_q     <= 1'b0;
                    desplaza_q <= 1'b0;
                    busy_q     <= 1'b0;
                    fin_q      <= 1'b0;
                end
            endcase
        end
    end

    // add/subtract decision is combinational on the live Booth pair during EVAL only
    always_comb begin
        carga_a_c = 1'b0;
        resta_c   = 1'b0;
        if (state == S_EVAL) begin
            carga_a_c = (pair == PAIR_ADD) || (pair == PAIR_SUB);
            resta_c   = (pair == PAIR_SUB);
        end
    end

    assign bus.init     = init_q;
    assign bus.carga_a  = carga_a_c;
    assign bus.resta    = resta_c;
    assign bus.desplaza = desplaza_q;
    assign bus.busy     = busy_q;
    assign bus.fin      = fin_q;
    assign bus.cuenta   = cnt_val;

endmodule

// File: tb/tb_control_booth.sv
// tb/tb_control_booth.sv - scoreboard bench for the Booth control unit with a small A/M/Q datapath
module tb_control_booth;

    typedef struct packed {
        logic       init;
        logic       carga_a;
        logic       resta;
        logic       desplaza;
        logic       busy;
        logic       fin;
        logic [3:0] cuenta;
    } obs_t;

    logic clk;
    logic reset;
    logic start;
    logic drv_q0;
    logic drv_q_1;
    logic use_dp;

    logic [5:0] dp_a;
    logic [5:0] dp_m;
    logic [4:0] dp_q;
    logic       dp_q1;
    logic [5:0] m_in;
    logic [4:0] q_in;

    int n_checks;
    int n_fail;

    obs_t exp_q[$];
    logic [1:0] pv [5];

    control_booth_if #(.CNT_W(4)) bus ();

    assign bus.start = start;
    assign bus.q0    = use_dp ? dp_q[0] : drv_q0;
    assign bus.q_1   = use_dp ? dp_q1   : drv_q_1;

    control_booth #(.N(5), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference A/M/Q/q_1 datapath steered by the controller outputs
    always @(posedge clk) begin
        if (bus.init) begin
            dp_a  <= 6'd0;
            dp_m  <= m_in;
            dp_q  <= q_in;
            dp_q1 <= 1'b0;
        end else if (bus.carga_a) begin
            dp_a <= bus.resta ? (dp_a - dp_m) : (dp_a + dp_m);
        end else if (bus.desplaza) begin
            {dp_a, dp_q, dp_q1} <= {dp_a[5], dp_a, dp_q};
        end
    end

    function automatic obs_t sample();
        obs_t o;
        o.init     = bus.init;
        o.carga_a  = bus.carga_a;
        o.resta    = bus.resta;
        o.desplaza = bus.desplaza;
        o.busy     = bus.busy;
        o.fin      = bus.fin;
        o.cuenta   = bus.cuenta;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic i, input logic c, input logic r, input logic d,
                        input logic b, input logic f, input logic [3:0] n);
        obs_t o;
        o = '{init: i, carga_a: c, resta: r, desplaza: d, busy: b, fin: f, cuenta: n};
        exp_q.push_back(o);
    endtask

    // monitor: every cycle with any active control line consumes one expected entry
    always @(negedge clk) begin
        obs_t o;
        obs_t e;
        if (reset) begin
            o = sample();
            if (o.init | o.carga_a | o.resta | o.desplaza | o.busy | o.fin) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %b with empty scoreboard at %0t", o, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL ctrl_vector: got %b expected %b (init,carga,resta,despl,busy,fin,cuenta) at %0t",
                                 o, e, $time);
                    end
                end
            end
        end
    end

    // one full run: pairs per iteration, d cycles of fin held in DONE
    task automatic do_run(input int d);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            push(1'b0, pv[i][1] ^ pv[i][0], pv[i] == 2'b10, 1'b0, 1'b1, 1'b0, 4'(5 - i));
            push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'(5 - i));
        end
        for (int j = 0; j < d; j++)
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        start = 1'b1;
        @(posedge clk) #1;
        if (d == 1) start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            {drv_q0, drv_q_1} = pv[i];
            @(posedge clk) #1;
            @(posedge clk) #1;
        end
        repeat (d) @(posedge clk) #1;
        check("fin_held_before_drop", {31'd0, bus.fin}, 32'd1);
        start = 1'b0;
        @(posedge clk) #1;
        check("fin_low_after_drop", {31'd0, bus.fin}, 32'd0);
        check("idle_cuenta", {28'd0, bus.cuenta}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b1;
        drv_q0   = 1'b0;
        drv_q_1  = 1'b0;
        use_dp   = 1'b0;
        m_in     = 6'd0;
        q_in     = 5'd0;

        // reset held with start high: everything quiet
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_outputs", {22'd0, sample()}, 32'd0);
        end
        @(posedge clk) #1;
        reset = 1'b1;

        // release with start high, then a pulsed start: pair 00 throughout
        pv = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        do_run(1);
        do_run(1);

        // subtract every iteration except an add in iteration 3
        pv = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        do_run(1);

        // start held through DONE, then a fresh run after dropping it
        pv = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b00};
        do_run(4);
        pv = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        do_run(1);

        // asynchronous reset in the SHIFT of iteration 3
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(5 - i));
            push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'(5 - i));
        end
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        drv_q0  = 1'b0;
        drv_q_1 = 1'b0;
        start   = 1'b1;
        repeat (7) @(posedge clk) #1;
        check("abort_shift_before", {27'd0, bus.desplaza, bus.cuenta}, {27'd0, 1'b1, 4'd3});
        #2 reset = 1'b0;
        #1;
        check("abort_desplaza", {31'd0, bus.desplaza}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_cuenta", {28'd0, bus.cuenta}, 32'd0);
        @(posedge clk) #1;
        reset = 1'b1;
        do_run(1);

        // integration: M=3, Q=-2 gives -6
        use_dp = 1'b1;
        m_in   = 6'd3;
        q_in   = 5'b11110;
        pv = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11};
        do_run(1);
        check("product_3_x_m2", {21'd0, dp_a, dp_q}, {21'd0, 11'h7FA});

        // integration: M=-5, Q=-5 gives +25
        m_in = 6'b111011;
        q_in = 5'b11011;
        pv = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        do_run(1);
        check("product_m5_x_m5", {21'd0, dp_a, dp_q}, 32'd25);

        repeat (3) @(posedge clk) #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
